// File: rtl/simp_operand_stage.sv
// Decode/operand-fetch stage feeding the 16-bit ALU; owns the 8-entry register file.
// Optional macro SIMP_WB_BYPASS_EN forwards a same-cycle writeback into the fetched operands.
module simp_operand_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              alu_valid,
  input  logic              alu_ready,
  output logic [2:0]        alu_ctrl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [REG_AW-1:0] alu_rd
);

  localparam int unsigned NREG = 1 << REG_AW;

  logic [DATA_W-1:0] rf_q [NREG];

  logic              valid_q, valid_d;
  logic [2:0]        ctrl_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [REG_AW-1:0] rd_q;

  logic [2:0]        op;
  logic              imm_sel;
  logic [REG_AW-1:0] rd, rs1, rs2;
  logic [DATA_W-1:0] rs1_val, rs2_val, b_val;
  logic              xfer;

  assign op      = in_instr[15:13];
  assign imm_sel = in_instr[12];
  assign rd      = in_instr[11:9];
  assign rs1     = in_instr[8:6];
  assign rs2     = in_instr[5:3];

  assign in_ready = !valid_q || alu_ready;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    rs1_val = (rs1 == '0) ? '0 : rf_q[rs1];
    rs2_val = (rs2 == '0) ? '0 : rf_q[rs2];
`ifdef SIMP_WB_BYPASS_EN
    if (wb_en && (wb_addr == rs1) && (rs1 != '0)) rs1_val = wb_data;
    if (wb_en && (wb_addr == rs2) && (rs2 != '0)) rs2_val = wb_data;
`endif
    b_val = imm_sel ? {{(DATA_W-6){1'b0}}, in_instr[5:0]} : rs2_val;
  end

  always_comb begin
    valid_d = valid_q;
    if (flush)          valid_d = 1'b0;
    else if (xfer)      valid_d = 1'b1;
    else if (alu_ready) valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  // A flushed transfer is dropped entirely, so the data registers only load on a kept transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      if (xfer && !flush) begin
        ctrl_q <= op;
        a_q    <= rs1_val;
        b_q    <= b_val;
        rd_q   <= rd;
      end
    end
  end

  assign alu_valid = valid_q;
  assign alu_ctrl  = ctrl_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_rd    = rd_q;

endmodule
